// File: rtl/bf_pkg.sv
// Shared opcode and state encodings for the tape data unit.
package bf_pkg;

    localparam int unsigned OP_WIDTH   = 3;
    localparam int unsigned BYTE_WIDTH = 8;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_MOVE = 3'd2,
        OP_IN   = 3'd3,
        OP_OUT  = 3'd4,
        OP_CLR  = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_BOOT     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_READY    = 3'd3,
        ST_WAIT_IN  = 3'd4,
        ST_WAIT_OUT = 3'd5
    } state_e;

endpackage

// File: rtl/bf_data_unit.sv
// Tape data unit: caches RAM[dp] in a cell register and executes data ops,
// writing modified cells back one cycle after acceptance.
module bf_data_unit
    import bf_pkg::*;
#(
    parameter int unsigned A_WIDTH = 12,
    parameter int unsigned D_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [OP_WIDTH-1:0]   op_code,
    input  logic [BYTE_WIDTH-1:0] op_arg,

    output logic                  mem_rce,
    output logic [A_WIDTH-1:0]    mem_ra,
    input  logic [D_WIDTH-1:0]    mem_rq,
    output logic                  mem_wce,
    output logic [A_WIDTH-1:0]    mem_wa,
    output logic [D_WIDTH-1:0]    mem_wd,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BYTE_WIDTH-1:0] in_data,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BYTE_WIDTH-1:0] out_data,

    output logic                  cell_zero,
    output logic [A_WIDTH-1:0]    dp
);

    state_e                  state_q, state_d;
    logic [A_WIDTH-1:0]      dp_q, dp_d;
    logic [D_WIDTH-1:0]      cell_q, cell_d;
    logic                    mem_wce_q, mem_wce_d;
    logic [A_WIDTH-1:0]      mem_wa_q, mem_wa_d;
    logic [D_WIDTH-1:0]      mem_wd_q, mem_wd_d;
    logic [BYTE_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    do_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            dp_q       <= '0;
            cell_q     <= '0;
            mem_wce_q  <= 1'b0;
            mem_wa_q   <= '0;
            mem_wd_q   <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            dp_q       <= dp_d;
            cell_q     <= cell_d;
            mem_wce_q  <= mem_wce_d;
            mem_wa_q   <= mem_wa_d;
            mem_wd_q   <= mem_wd_d;
            out_data_q <= out_data_d;
        end
    end

    // Next state, cell update and write-back scheduling.
    always_comb begin
        state_d    = state_q;
        dp_d       = dp_q;
        cell_d     = cell_q;
        out_data_d = out_data_q;
        do_write   = 1'b0;
        mem_wce_d  = 1'b0;
        mem_wa_d   = mem_wa_q;
        mem_wd_d   = mem_wd_q;

        case (state_q)
            ST_BOOT:    state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                cell_d  = mem_rq;
                state_d = ST_READY;
            end
            ST_READY: begin
                if (op_valid) begin
                    case (op_code)
                        OP_ADD: begin
                            cell_d   = cell_q + D_WIDTH'($signed(op_arg));
                            do_write = 1'b1;
                        end
                        OP_CLR: begin
                            cell_d   = '0;
                            do_write = 1'b1;
                        end
                        OP_MOVE: begin
                            // A zero-length move keeps the cached cell valid.
                            if (op_arg != '0) begin
                                dp_d    = dp_q + A_WIDTH'($signed(op_arg));
                                state_d = ST_FETCH;
                            end
                        end
                        OP_IN:  state_d = ST_WAIT_IN;
                        OP_OUT: begin
                            out_data_d = BYTE_WIDTH'(cell_q);
                            state_d    = ST_WAIT_OUT;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT_IN: begin
                if (in_valid) begin
                    cell_d   = D_WIDTH'(in_data);
                    do_write = 1'b1;
                    state_d  = ST_READY;
                end
            end
            ST_WAIT_OUT: begin
                if (out_ready) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        if (do_write) begin
            mem_wce_d = 1'b1;
            mem_wa_d  = dp_q;
            mem_wd_d  = cell_d;
        end
    end

    // Handshakes and read port decode straight from the state register.
    assign op_ready  = (state_q == ST_READY);
    assign in_ready  = (state_q == ST_WAIT_IN);
    assign out_valid = (state_q == ST_WAIT_OUT);
    assign out_data  = out_data_q;
    assign mem_rce   = (state_q == ST_FETCH);
    assign mem_ra    = dp_q;
    assign mem_wce   = mem_wce_q;
    assign mem_wa    = mem_wa_q;
    assign mem_wd    = mem_wd_q;
    assign cell_zero = (cell_q == '0);
    assign dp        = dp_q;

endmodule

// File: doc/bf_data_unit.md
BF_DATA_UNIT -- requirements
Module: bf_data_unit

Interface
REQ-001 Parameter A_WIDTH, default 12, tape address width in bits.
REQ-002 Parameter D_WIDTH, default 8, cell width in bits.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 op_valid / op_ready  in / out  1 / 1  operation handshake; transfer when both high at a rising edge.
REQ-006 op_code  in  3  0 NOP, 1 ADD, 2 MOVE, 3 IN, 4 OUT, 5 CLR; 6-7 treated as NOP.
REQ-007 op_arg  in  8  signed two's-complement operand for ADD/MOVE; ignored otherwise.
REQ-008 mem_rce, mem_ra  out  1, A_WIDTH  tape RAM read enable/address; RAM returns data one cycle later.
REQ-009 mem_rq  in  D_WIDTH  tape RAM read data.
REQ-010 mem_wce, mem_wa, mem_wd  out  1, A_WIDTH, D_WIDTH  tape RAM write enable/address/data.
REQ-011 in_valid / in_ready / in_data  in / out / in  1 / 1 / 8  byte input channel.
REQ-012 out_valid / out_ready / out_data  out / in / out  1 / 1 / 8  byte output channel.
REQ-013 cell_zero  out  1  high when cached current cell equals 0 (branch condition).
REQ-014 dp  out  A_WIDTH  current data pointer.

Function
REQ-015 Unit SHALL hold a cell cache register always equal to RAM[dp] whenever op_ready is high.
REQ-016 States SHALL be BOOT, FETCH, CAPTURE, READY, WAIT_IN, WAIT_OUT; op_ready = (state == READY).
REQ-017 BOOT SHALL go to FETCH unconditionally; FETCH asserts mem_rce with mem_ra = dp, goes to CAPTURE; CAPTURE loads cell <= mem_rq, goes to READY.
REQ-018 ADD accepted in cycle t: cell <= (cell + op_arg) mod 2^D_WIDTH at the end of t; mem_wce=1, mem_wa=dp, mem_wd=new cell during t+1; state stays READY.
REQ-019 CLR SHALL behave as ADD but with result 0.
REQ-020 MOVE with op_arg != 0: dp <= (dp + sign-extended op_arg) mod 2^A_WIDTH, then FETCH, CAPTURE; op_ready returns 3 cycles after acceptance.
REQ-021 MOVE with op_arg == 0 and NOP SHALL consume the op in one cycle with no RAM access.
REQ-022 IN: go to WAIT_IN with in_ready=1; on in_valid, cell <= in_data, write issued the following cycle as in REQ-018, return to READY.
REQ-023 OUT: out_data <= cell, out_valid held high in WAIT_OUT until out_ready; out_data stable while out_valid high; return to READY on transfer.
REQ-024 Back-to-back ADD/CLR ops SHALL be accepted every cycle; each produces one RAM write.
REQ-025 mem_rce and mem_wce SHALL never target the same address in the same cycle; a write pending from a preceding ADD completes before any FETCH read.
REQ-026 cell_zero SHALL be decoded from the cell register and is valid whenever op_ready is high.
REQ-027 mem_wce, mem_wa, mem_wd SHALL be driven from registers; mem_rce, mem_ra decode directly from state and dp.

Reset
REQ-028 On rst: state=BOOT, dp=0, cell=0, op_ready=0, mem_rce=0, mem_wce=0, mem_wa=0, mem_wd=0, in_ready=0, out_valid=0, out_data=0.
REQ-029 Reset mid-operation SHALL abort any op, drop pending writes and handshakes; RAM contents are not cleared, so the cell is reloaded through BOOT/FETCH/CAPTURE.

Structure
REQ-030 Opcode constants and state encoding SHALL live in shared package bf_pkg.
REQ-031 No sub-modules; unit connects directly to the tape RAM instance.

Verification
REQ-032 Reset, RAM preloaded RAM[0]=0x05 -> op_ready rises 3 cycles after reset release, cell_zero=0.
REQ-033 ADD +3, ADD +255, ADD -2 back-to-back from cell 0 -> three consecutive writes 0x03, 0x02, 0x00; cell_zero=1.
REQ-034 MOVE -1 at dp=0 -> dp=0xFFF, read issued to 0xFFF, op_ready returns 3 cycles later.
REQ-035 ADD +7, MOVE +1, MOVE -1 -> write 0x07 at dp then read back 0x07 from RAM, cell_zero=0.
REQ-036 OUT with out_ready low 5 cycles -> out_valid held, out_data constant; IN 0x41 -> RAM[dp]=0x41.
REQ-037 rst asserted in WAIT_OUT -> out_valid=0 immediately, no write issued, cell reloaded from RAM[0].
